// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature step decoder.
//   quad_state_t : Gray-code phase, encoded directly as {A,B}
//   ERR_COUNT_W  : width of the optional saturating error counter
//   quad_fwd/rev : phase that follows a given phase in forward/reverse rotation
package quad_pkg;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S10 = 2'b10,
        S11 = 2'b11,
        S01 = 2'b01
    } quad_state_t;

    localparam int unsigned ERR_COUNT_W = 8;

    // Forward rotation: 00 -> 10 -> 11 -> 01 -> 00
    function automatic quad_state_t quad_fwd(input quad_state_t s);
        quad_state_t n;
        n = S00;
        unique case (s)
            S00: n = S10;
            S10: n = S11;
            S11: n = S01;
            S01: n = S00;
        endcase
        return n;
    endfunction

    // Reverse rotation: 00 -> 01 -> 11 -> 10 -> 00
    function automatic quad_state_t quad_rev(input quad_state_t s);
        quad_state_t n;
        n = S00;
        unique case (s)
            S00: n = S01;
            S01: n = S11;
            S11: n = S10;
            S10: n = S00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sync_filter.sv
// Per-channel front end: multi-flop synchroniser followed by a persistence
// filter. A synchronised change is accepted into dout only after it has
// differed from the current filtered value for FILTER_CYCLES consecutive
// cycles.
//   clk         : system clock
//   rst         : asynchronous active-high reset (clears everything to 0)
//   din         : raw asynchronous channel input
//   load_direct : when high, dout loads the synchroniser output unfiltered
//   dout        : filtered channel value
module sync_filter #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic load_direct,
    output logic dout
);

    localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   filt_q, filt_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (load_direct) begin
            filt_d = sync_out;
            cnt_d  = '0;
        end else if (sync_out != filt_q) begin
            // This cycle is the FILTER_CYCLES-th consecutive mismatch.
            if (cnt_q == CntW'(FILTER_CYCLES - 1)) begin
                filt_d = sync_out;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronises and filters ChA/ChB, tracks the
// Gray-code phase and emits single-cycle registered step pulses (x4 decoding).
//   clk      : system clock (rising edge)
//   rst      : asynchronous active-high reset
//   enable   : gates Mas/Menos/Error; phase tracking continues while low
//   ChA, ChB : raw asynchronous encoder channels
//   Mas      : one-cycle pulse per forward step
//   Menos    : one-cycle pulse per reverse step
//   Error    : one-cycle pulse when both channels changed at once
//   ErrCount : saturating count of illegal transitions, present only when
//              QUAD_ERR_COUNT_EN is defined
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic ChA,
    input  logic ChB,
    output logic Mas,
    output logic Menos,
    output logic Error
`ifdef QUAD_ERR_COUNT_EN
    ,
    output logic [ERR_COUNT_W-1:0] ErrCount
`endif
);

    localparam int unsigned BlankCycles = SYNC_STAGES + FILTER_CYCLES;
    localparam int unsigned BlankW      = $clog2(BlankCycles + 1);

    logic [BlankW-1:0] blank_q, blank_d;
    logic              load_direct;
    logic              fsm_load_q;
    logic              filt_a, filt_b;
    quad_state_t       phase_now;
    quad_state_t       state_q, state_d;
    logic              mas_d, menos_d, err_evt, err_d;
    logic              mas_q, menos_q, err_q;

    sync_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt_a (
        .clk        (clk),
        .rst        (rst),
        .din        (ChA),
        .load_direct(load_direct),
        .dout       (filt_a)
    );

    sync_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt_b (
        .clk        (clk),
        .rst        (rst),
        .din        (ChB),
        .load_direct(load_direct),
        .dout       (filt_b)
    );

    assign phase_now = quad_state_t'({filt_a, filt_b});

    // Post-reset blanking: counts down once and then sticks at zero.
    assign load_direct = (blank_q != '0);
    assign blank_d     = load_direct ? (blank_q - BlankW'(1)) : blank_q;

    // The filters load the synchroniser output during blanking; the FSM sees
    // that value one cycle later, so it stays in direct-load one cycle longer
    // than the filters. This keeps state equal to the filtered phase at the
    // moment pulses become possible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q    <= BlankW'(BlankCycles);
            fsm_load_q <= 1'b1;
        end else begin
            blank_q    <= blank_d;
            fsm_load_q <= load_direct;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S00;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: always follows the filtered phase, including after an
    // illegal diagonal jump.
    always_comb begin
        state_d = phase_now;
    end

    // FSM outputs: classify the move from state_q to the filtered phase.
    always_comb begin
        mas_d   = 1'b0;
        menos_d = 1'b0;
        err_evt = 1'b0;
        if (!fsm_load_q) begin
            if (phase_now == quad_fwd(state_q)) begin
                mas_d = enable;
            end else if (phase_now == quad_rev(state_q)) begin
                menos_d = enable;
            end else if (phase_now != state_q) begin
                err_evt = 1'b1;
            end
        end
        err_d = err_evt & enable;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mas_q   <= 1'b0;
            menos_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mas_q   <= mas_d;
            menos_q <= menos_d;
            err_q   <= err_d;
        end
    end

    assign Mas   = mas_q;
    assign Menos = menos_q;
    assign Error = err_q;

`ifdef QUAD_ERR_COUNT_EN
    logic [ERR_COUNT_W-1:0] err_cnt_q, err_cnt_d;

    // Counts illegal transitions regardless of enable; saturates at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_evt && (err_cnt_q != {ERR_COUNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ErrCount = err_cnt_q;
`endif

endmodule
